// File: rtl/soc_rst_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset cause codes
// and a small sizing helper.
package soc_rst_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [CAUSE_W-1:0] CAUSE_POR = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_SW  = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_WDT = 2'b10;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/soc_wdt_counter.sv
// Kickable watchdog: load register, down-counter and a one-cycle expiry pulse.
// It only counts while the sequencer is running and the enable is high.
module soc_wdt_counter #(
  parameter int WDT_WIDTH   = 16,
  parameter int WDT_DEFAULT = 10000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  input  logic                 i_loadNow,
  input  logic                 i_en,
  input  logic                 i_kick,
  input  logic                 i_loadWe,
  input  logic [WDT_WIDTH-1:0] i_load,
  input  logic                 i_suppress,
  output logic                 o_expireNow,
  output logic                 o_expired
);

  localparam logic [WDT_WIDTH-1:0] DEFAULT_VAL = WDT_WIDTH'(WDT_DEFAULT);

  logic [WDT_WIDTH-1:0] r_loadReg;
  logic [WDT_WIDTH-1:0] r_cnt;
  logic                 r_expired;
  logic                 w_expire;

  // A kick or a software reset in the same cycle wins over an expiry.
  assign w_expire = i_run && i_en && !i_kick && !i_suppress && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_loadReg <= DEFAULT_VAL;
      r_cnt     <= DEFAULT_VAL;
      r_expired <= 1'b0;
    end else begin
      r_expired <= w_expire;
      if (i_loadWe && (i_load != '0))
        r_loadReg <= i_load;
      if (i_loadNow)
        r_cnt <= r_loadReg;
      else if (i_run && i_en) begin
        if (i_kick)
          r_cnt <= r_loadReg;
        else if (r_cnt != '0)
          r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_expireNow = w_expire;
  assign o_expired   = r_expired;

endmodule

// File: rtl/soc_rst_seq.sv
// Reset sequencer: holds all domain resets after any reset source, releases the
// channels one at a time, then supervises the running system with the watchdog.
module soc_rst_seq
  import soc_rst_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int WDT_WIDTH      = 16,
  parameter int WDT_DEFAULT    = 10000
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 sw_rst_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic                 wdt_load_we,
  input  logic [WDT_WIDTH-1:0] wdt_load,
  output logic [NUM_CH-1:0]    rst_n_out,
  output logic                 all_released,
  output logic                 busy,
  output logic                 wdt_expired,
  output logic [CAUSE_W-1:0]   rst_cause
);

  localparam int CNT_W = $clog2(maxInt(HOLD_CYCLES, STAGGER_CYCLES)) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  state_t               r_state, w_stateNext;
  logic [CNT_W-1:0]     r_cnt, w_cntNext;
  logic [IDX_W-1:0]     r_chIdx, w_chIdxNext;
  logic [NUM_CH-1:0]    r_rstN, w_rstNNext;
  logic                 r_allRel, w_allRelNext;
  logic                 r_busy, w_busyNext;
  logic [CAUSE_W-1:0]   r_cause, w_causeNext;
  logic                 w_expireNow;
  logic                 w_enterRun;
  logic                 w_wdtExpired;

  // Software reset outranks watchdog expiry; both restart the hold count from zero.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_chIdxNext  = r_chIdx;
    w_rstNNext   = r_rstN;
    w_allRelNext = r_allRel;
    w_busyNext   = r_busy;
    w_causeNext  = r_cause;
    if (sw_rst_req || w_expireNow) begin
      w_stateNext  = HOLD;
      w_cntNext    = '0;
      w_chIdxNext  = '0;
      w_rstNNext   = '0;
      w_allRelNext = 1'b0;
      w_busyNext   = 1'b1;
      w_causeNext  = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_cntNext     = '0;
            w_chIdxNext   = '0;
            w_rstNNext[0] = 1'b1;
            if (NUM_CH == 1) begin
              w_stateNext  = RUN;
              w_allRelNext = 1'b1;
              w_busyNext   = 1'b0;
            end else begin
              w_stateNext = STAGGER;
            end
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        STAGGER: begin
          if (r_cnt == STAG_LAST) begin
            w_cntNext   = '0;
            w_chIdxNext = r_chIdx + 1'b1;
            for (int i = 1; i < NUM_CH; i++) begin
              if (i == int'(r_chIdx) + 1)
                w_rstNNext[i] = 1'b1;
            end
            if (int'(r_chIdx) == NUM_CH - 2) begin
              w_stateNext  = RUN;
              w_allRelNext = 1'b1;
              w_busyNext   = 1'b0;
            end
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
        RUN: ;
        default: w_stateNext = HOLD;
      endcase
    end
  end

  assign w_enterRun = (w_stateNext == RUN) && (r_state != RUN);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_chIdx  <= '0;
      r_rstN   <= '0;
      r_allRel <= 1'b0;
      r_busy   <= 1'b1;
      r_cause  <= CAUSE_POR;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_chIdx  <= w_chIdxNext;
      r_rstN   <= w_rstNNext;
      r_allRel <= w_allRelNext;
      r_busy   <= w_busyNext;
      r_cause  <= w_causeNext;
    end
  end

  soc_wdt_counter #(
    .WDT_WIDTH   (WDT_WIDTH),
    .WDT_DEFAULT (WDT_DEFAULT)
  ) u_wdt (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_run       (r_state == RUN),
    .i_loadNow   (w_enterRun),
    .i_en        (wdt_en),
    .i_kick      (wdt_kick),
    .i_loadWe    (wdt_load_we),
    .i_load      (wdt_load),
    .i_suppress  (sw_rst_req),
    .o_expireNow (w_expireNow),
    .o_expired   (w_wdtExpired)
  );

  assign rst_n_out    = r_rstN;
  assign all_released = r_allRel;
  assign busy         = r_busy;
  assign wdt_expired  = w_wdtExpired;
  assign rst_cause    = r_cause;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Directed testbench for soc_rst_seq with NUM_CH=4, HOLD_CYCLES=5, STAGGER_CYCLES=2.
// Expected values are hand-derived release schedules and watchdog expiry edges.
module tb_soc_rst_seq;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        sw_rst_req = 1'b0;
  logic        wdt_en = 1'b0;
  logic        wdt_kick = 1'b0;
  logic        wdt_load_we = 1'b0;
  logic [15:0] wdt_load = 16'd0;
  logic [3:0]  rst_n_out;
  logic        all_released;
  logic        busy;
  logic        wdt_expired;
  logic [1:0]  rst_cause;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  soc_rst_seq #(
    .NUM_CH         (4),
    .HOLD_CYCLES    (5),
    .STAGGER_CYCLES (2),
    .WDT_WIDTH      (16),
    .WDT_DEFAULT    (10000)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .sw_rst_req   (sw_rst_req),
    .wdt_en       (wdt_en),
    .wdt_kick     (wdt_kick),
    .wdt_load_we  (wdt_load_we),
    .wdt_load     (wdt_load),
    .rst_n_out    (rst_n_out),
    .all_released (all_released),
    .busy         (busy),
    .wdt_expired  (wdt_expired),
    .rst_cause    (rst_cause)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Channel i is released HOLD + i*STAGGER = 5 + 2i edges after the reset source goes away.
  function automatic logic [3:0] expRst(input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k >= 5 + 2 * i);
    return r;
  endfunction

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (4) tick();
    checks++; if (rst_n_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rst_n got %b want 0000", rst_n_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b want 1", busy); end
    checks++; if (all_released !== 1'b0) begin errors++; $display("[TB] FAIL reset_all_released got %b want 0", all_released); end
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL reset_wdt_expired got %b want 0", wdt_expired); end
    checks++; if (rst_cause !== 2'b00) begin errors++; $display("[TB] FAIL reset_cause got %b want 00", rst_cause); end
    HRESET = 1'b0;
  endtask

  task automatic test_por_release();
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++; if (rst_n_out !== expRst(k)) begin errors++; $display("[TB] FAIL por_rst_n edge %0d got %b want %b", k, rst_n_out, expRst(k)); end
      if (k >= 10) begin
        checks++; if (busy !== (k < 11)) begin errors++; $display("[TB] FAIL por_busy edge %0d got %b want %b", k, busy, (k < 11)); end
        checks++; if (all_released !== (k >= 11)) begin errors++; $display("[TB] FAIL por_all_released edge %0d got %b want %b", k, all_released, (k >= 11)); end
      end
    end
    checks++; if (rst_cause !== 2'b00) begin errors++; $display("[TB] FAIL por_cause got %b want 00", rst_cause); end
  endtask

  task automatic test_wdt_expiry();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    wdt_en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      wdt_load    = 16'd8;
      wdt_load_we = (k == 7);
      tick();
    end
    wdt_load_we = 1'b0;
    checks++; if (rst_n_out !== 4'b1111) begin errors++; $display("[TB] FAIL wdt_run_entry got %b want 1111", rst_n_out); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (wdt_expired !== (k == 9)) begin errors++; $display("[TB] FAIL wdt_pulse edge %0d got %b want %b", k, wdt_expired, (k == 9)); end
    end
    checks++; if (rst_n_out !== 4'b0000) begin errors++; $display("[TB] FAIL wdt_rst_n got %b want 0000", rst_n_out); end
    checks++; if (rst_cause !== 2'b10) begin errors++; $display("[TB] FAIL wdt_cause got %b want 10", rst_cause); end
    checks++; if (busy !== 1'b1 || all_released !== 1'b0) begin errors++; $display("[TB] FAIL wdt_flags got busy=%b all=%b want busy=1 all=0", busy, all_released); end
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++; if (rst_n_out !== expRst(k)) begin errors++; $display("[TB] FAIL wdt_rerelease edge %0d got %b want %b", k, rst_n_out, expRst(k)); end
      if (k == 1) begin
        checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL wdt_pulse_width got %b want 0", wdt_expired); end
      end
    end
    checks++; if (rst_cause !== 2'b10) begin errors++; $display("[TB] FAIL wdt_cause_hold got %b want 10", rst_cause); end
  endtask

  task automatic test_kicks();
    // Counter is 8 at RUN entry; kicks every 6th edge keep it at or above 3.
    for (int j = 0; j < 100; j++) begin
      wdt_kick = ((j % 6) == 5);
      tick();
      checks++; if (wdt_expired !== 1'b0 || rst_n_out !== 4'b1111) begin errors++; $display("[TB] FAIL kick_loop cycle %0d got exp=%b rst=%b want exp=0 rst=1111", j, wdt_expired, rst_n_out); end
    end
    wdt_kick = 1'b0;
    repeat (4) tick();
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL kick_drain got %b want 0", wdt_expired); end
    // Counter is 0 now: kick on the expiry cycle while writing a new load value.
    wdt_kick    = 1'b1;
    wdt_load    = 16'd3;
    wdt_load_we = 1'b1;
    tick();
    wdt_kick    = 1'b0;
    wdt_load_we = 1'b0;
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL kick_at_zero got %b want 0", wdt_expired); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (wdt_expired !== (k == 9)) begin errors++; $display("[TB] FAIL kick_reload edge %0d got %b want %b", k, wdt_expired, (k == 9)); end
    end
    checks++; if (rst_cause !== 2'b10) begin errors++; $display("[TB] FAIL kick_cause got %b want 10", rst_cause); end
    wdt_en = 1'b0;
    repeat (11) tick();
    checks++; if (rst_n_out !== 4'b1111 || all_released !== 1'b1) begin errors++; $display("[TB] FAIL kick_rerelease got rst=%b all=%b want 1111/1", rst_n_out, all_released); end
  endtask

  task automatic test_sw_reset();
    sw_rst_req = 1'b1;
    tick();
    checks++; if (rst_n_out !== 4'b0000) begin errors++; $display("[TB] FAIL sw_rst_n got %b want 0000", rst_n_out); end
    checks++; if (rst_cause !== 2'b01) begin errors++; $display("[TB] FAIL sw_cause got %b want 01", rst_cause); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sw_busy got %b want 1", busy); end
    repeat (2) tick();
    sw_rst_req = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++; if (rst_n_out !== expRst(k)) begin errors++; $display("[TB] FAIL sw_release edge %0d got %b want %b", k, rst_n_out, expRst(k)); end
    end
    checks++; if (rst_cause !== 2'b01) begin errors++; $display("[TB] FAIL sw_cause_hold got %b want 01", rst_cause); end
    // Load register is 3 here, so the fourth enabled edge is the expiry edge.
    wdt_en = 1'b1;
    repeat (3) tick();
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL sw_pre_expiry got %b want 0", wdt_expired); end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    wdt_en     = 1'b0;
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL sw_vs_wdt_pulse got %b want 0", wdt_expired); end
    checks++; if (rst_cause !== 2'b01) begin errors++; $display("[TB] FAIL sw_vs_wdt_cause got %b want 01", rst_cause); end
    checks++; if (rst_n_out !== 4'b0000) begin errors++; $display("[TB] FAIL sw_vs_wdt_rst_n got %b want 0000", rst_n_out); end
    tick();
    checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL sw_vs_wdt_late got %b want 0", wdt_expired); end
  endtask

  task automatic test_mid_stagger();
    sw_rst_req  = 1'b1;
    wdt_load    = 16'd8;
    wdt_load_we = 1'b1;
    tick();
    sw_rst_req  = 1'b0;
    wdt_load_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wdt_load    = 16'd0;
      wdt_load_we = (k == 3);
      sw_rst_req  = (k == 8);
      tick();
      if (k < 8) begin
        checks++; if (rst_n_out !== expRst(k)) begin errors++; $display("[TB] FAIL mid_release edge %0d got %b want %b", k, rst_n_out, expRst(k)); end
      end else begin
        checks++; if (rst_n_out !== 4'b0000) begin errors++; $display("[TB] FAIL mid_abort got %b want 0000", rst_n_out); end
        checks++; if (rst_cause !== 2'b01) begin errors++; $display("[TB] FAIL mid_cause got %b want 01", rst_cause); end
      end
    end
    sw_rst_req  = 1'b0;
    wdt_load_we = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++; if (rst_n_out !== expRst(k)) begin errors++; $display("[TB] FAIL mid_restart edge %0d got %b want %b", k, rst_n_out, expRst(k)); end
    end
    // Entry loaded 8 (the zero write was dropped); 4 enabled edges, 50 disabled, then 5 more.
    wdt_en = 1'b1;
    repeat (4) tick();
    wdt_en = 1'b0;
    for (int j = 0; j < 50; j++) begin
      tick();
      checks++; if (wdt_expired !== 1'b0) begin errors++; $display("[TB] FAIL mid_hold cycle %0d got %b want 0", j, wdt_expired); end
    end
    wdt_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (wdt_expired !== (k == 5)) begin errors++; $display("[TB] FAIL mid_resume edge %0d got %b want %b", k, wdt_expired, (k == 5)); end
    end
    wdt_en = 1'b0;
    repeat (11) tick();
    checks++; if (rst_n_out !== 4'b1111) begin errors++; $display("[TB] FAIL mid_final got %b want 1111", rst_n_out); end
  endtask

  task automatic test_hreset_run();
    int n;
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    checks++; if (rst_cause !== 2'b00) begin errors++; $display("[TB] FAIL hrst_cause got %b want 00", rst_cause); end
    checks++; if (rst_n_out !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL hrst_outputs got rst=%b busy=%b want 0000/1", rst_n_out, busy); end
    wdt_en = 1'b1;
    repeat (11) tick();
    checks++; if (rst_n_out !== 4'b1111) begin errors++; $display("[TB] FAIL hrst_release got %b want 1111", rst_n_out); end
    // Load register is back to 10000, so expiry is 10001 edges after RUN entry.
    n = 0;
    while (!wdt_expired && n < 20000) begin
      tick();
      n++;
    end
    checks++; if (n != 10001) begin errors++; $display("[TB] FAIL hrst_default_load expiry after %0d edges want 10001", n); end
    checks++; if (rst_cause !== 2'b10) begin errors++; $display("[TB] FAIL hrst_expiry_cause got %b want 10", rst_cause); end
    wdt_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_por_release();
    test_wdt_expiry();
    test_kicks();
    test_sw_reset();
    test_mid_stagger();
    test_hreset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_rst_seq.md
Name: soc_rst_seq

Overview:
- Parametrised reset sequencer and watchdog for the AHB-Lite SoC.
- Generates NUM_CH active-low domain resets from one synchronous active-high system reset:
  - a power-on hold period;
  - staggered per-channel release.
- Supervises the running system with a kickable watchdog.
- Software or watchdog expiry re-enters the full reset sequence and records the cause.
- Sits beside the bus fabric; its channel outputs drive HRESETn of masters, slaves and peripherals.

Parameters:
- NUM_CH, 4, number of reset channels; >=1.
- HOLD_CYCLES, 5, cycles all channels are held after a reset source goes away; >=1.
- STAGGER_CYCLES, 2, cycles between successive channel releases; >=1.
- WDT_WIDTH, 16, watchdog counter and load register width.
- WDT_DEFAULT, 10000, load register reset value; nonzero, fits WDT_WIDTH.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset (one clock, sampled on rising HCLK).
- sw_rst_req  in  1  level; restarts the sequence.
- wdt_en  in  1  watchdog counts only when high.
- wdt_kick  in  1  reloads the watchdog.
- wdt_load_we  in  1  write strobe for wdt_load.
- wdt_load  in  WDT_WIDTH  new load value.
- rst_n_out  out  NUM_CH  active-low channel resets.
- all_released  out  1  all channels released.
- busy  out  1  sequence in progress.
- wdt_expired  out  1  one-cycle pulse on expiry.
- rst_cause  out  2  00 POR, 01 SW, 10 WDT.

Behaviour:
- Reset (HRESET=1 at an edge) forces:
  - state=HOLD, cnt=0, ch_idx=0;
  - rst_n_out=0, all_released=0, busy=1, wdt_expired=0;
  - rst_cause=00, load_reg=WDT_DEFAULT, wdt_cnt=WDT_DEFAULT.
- All outputs are registered. No combinational path from inputs to outputs.
- HOLD state:
  - rst_n_out all 0;
  - cnt increments each cycle;
  - on the HOLD_CYCLES-th edge after the reset source is removed, rst_n_out[0]<=1 and the block moves to STAGGER (or RUN if NUM_CH=1).
- STAGGER state:
  - every STAGGER_CYCLES edges, the next channel (ascending index) is set to 1;
  - the edge releasing channel NUM_CH-1 also sets all_released<=1, busy<=0 and state<=RUN.
  - Released channels never re-assert, except on a reset re-entry.
- Release timing: channel i rises HOLD_CYCLES + i*STAGGER_CYCLES edges after the reset source is removed.
- RUN state:
  - wdt_cnt is loaded from load_reg on the entry edge;
  - each cycle with wdt_en=1:
    - kick -> wdt_cnt<=load_reg;
    - else if wdt_cnt==0 -> expiry;
    - else wdt_cnt--.
  - wdt_en=0 holds wdt_cnt.
  - Expiry occurs load+1 cycles after RUN entry or after the last kick.
- Expiry:
  - wdt_expired=1 for exactly one cycle;
  - rst_cause<=10;
  - state<=HOLD and all rst_n_out<=0 on the same edge;
  - all_released<=0, busy<=1.
- sw_rst_req=1 in any state:
  - next edge: HOLD, cnt=0, all channels 0, rst_cause<=01.
  - While held high the sequence stays in HOLD with cnt at 0; the hold count starts on the first edge with it low.
- Simultaneous events:
  - HRESET beats everything.
  - sw_rst_req beats expiry: cause=01, no wdt_expired pulse.
  - kick beats expiry in the same cycle.
- wdt_load_we:
  - writes load_reg in any state; takes effect at the next reload;
  - a write of 0 is ignored;
  - a write coincident with a kick: kick loads the old value.
- rst_cause holds until the next reset event. HRESET sets it to 00.
- Mid-sequence reset (any source during HOLD/STAGGER): already-released channels return to 0 on the next edge; the sequence restarts from the hold count.

Decomposition:
- Package soc_rst_pkg holds:
  - state encodings HOLD/STAGGER/RUN;
  - cause codes CAUSE_POR/CAUSE_SW/CAUSE_WDT;
  - the 2-bit cause width.
- Sub-module soc_wdt_counter contains load_reg, wdt_cnt, kick/enable/expiry logic and the expired pulse. It is parametrised by WDT_WIDTH and WDT_DEFAULT.
- The FSM, hold/stagger counters and channel register stay in soc_rst_seq.

Test Plan:
All cases use NUM_CH=4, HOLD_CYCLES=5, STAGGER_CYCLES=2.
- Power-on: HRESET=1 for 4 cycles, then 0.
  - rst_n_out goes 0001/0011/0111/1111 at edges 5/7/9/11 after release.
  - all_released and busy change at edge 11; rst_cause=00.
- Watchdog expiry: write wdt_load=8 during STAGGER, wdt_en=1, no kick.
  - wdt_expired pulses 9 cycles after RUN entry; rst_n_out=0000 the same edge; rst_cause=10.
  - Re-release follows the power-on timing.
- Kicks: load=8, kick every 6 cycles for 100 cycles -> no expiry.
  - Kick on the exact wdt_cnt==0 cycle -> no expiry, reload to 8.
- Software reset: sw_rst_req=1 for 3 cycles in RUN.
  - All channels 0 the next edge; cause=01.
  - Channel 0 rises 5 edges after sw_rst_req falls.
  - sw_rst_req coincident with expiry -> cause=01, no pulse.
- Mid-stagger: sw_rst_req=1 for 1 cycle right after rst_n_out=0011.
  - Outputs 0000 the next edge, full restart; wdt_en=0 in RUN holds wdt_cnt constant for 50 cycles.
- Load edge cases: wdt_load_we with value 0 -> load_reg unchanged. HRESET=1 in RUN -> cause=00, load_reg=10000.
